// File: rtl/id_hazard_if.sv
// id_hazard_if: IF/ID + EX/MEM inputs and decoded ID/EX controls of the hazard controller
interface id_hazard_if;
    logic [31:0] instr_id;
    logic        MemRead_ex;
    logic [4:0]  rt_ex;
    logic        Jump_ex;
    logic        branch_taken_mem;
    logic        RegWrite_id;
    logic        MemtoReg_id;
    logic        Jump_id;
    logic        Branch_id;
    logic        MemRead_id;
    logic        MemWrite_id;
    logic        RegDst_id;
    logic        ALUSrc_id;
    logic [1:0]  ALUOp_id;
    logic        illegal_id;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;

    modport master (
        output instr_id, MemRead_ex, rt_ex, Jump_ex, branch_taken_mem,
        input  RegWrite_id, MemtoReg_id, Jump_id, Branch_id, MemRead_id, MemWrite_id,
               RegDst_id, ALUSrc_id, ALUOp_id, illegal_id,
               pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush
    );

    modport slave (
        input  instr_id, MemRead_ex, rt_ex, Jump_ex, branch_taken_mem,
        output RegWrite_id, MemtoReg_id, Jump_id, Branch_id, MemRead_id, MemWrite_id,
               RegDst_id, ALUSrc_id, ALUOp_id, illegal_id,
               pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID main decoder with load-use stall, redirect flush and event counters
module id_hazard_ctrl #(
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_clr,
    id_hazard_if.slave       b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int RW = IMEM_LAT > 0 ? $clog2(IMEM_LAT + 1) : 1;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [5:0]    op;
    logic [4:0]    rs, rt;
    logic [10:0]   dec;
    logic          hz, redir, stall, bubble;
    logic          unused_lo;

    assign op        = b.instr_id[31:26];
    assign rs        = b.instr_id[25:21];
    assign rt        = b.instr_id[20:16];
    assign unused_lo = ^b.instr_id[15:0];

    // main decoder: {RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump ALUOp illegal}
    always_comb begin
        case (op)
            OP_R:    dec = 11'b1_0_0_1_0_0_0_0_10_0;
            OP_LW:   dec = 11'b0_1_1_1_1_0_0_0_00_0;
            OP_SW:   dec = 11'b0_1_0_0_0_1_0_0_00_0;
            OP_BEQ:  dec = 11'b0_0_0_0_0_0_1_0_01_0;
            OP_ADDI: dec = 11'b0_1_0_1_0_0_0_0_00_0;
            OP_J:    dec = 11'b0_0_0_0_0_0_0_1_00_0;
            default: dec = 11'b0_0_0_0_0_0_0_0_00_1;
        endcase
    end

    // hazard detection, redirect/stall priority and pipeline register controls
    always_comb begin
        hz     = b.MemRead_ex && b.rt_ex != 5'd0 &&
                 (b.rt_ex == rs || (b.rt_ex == rt && (op == OP_R || op == OP_SW || op == OP_BEQ)));
        redir  = b.branch_taken_mem || b.Jump_ex;
        stall  = state_q == RUN && hz && !redir;
        bubble = !reset || redir || stall || state_q == FLUSH;
        b.pc_write     = reset && !stall;
        b.if_id_write  = reset && !stall;
        b.if_id_flush  = !reset || redir || state_q == FLUSH;
        b.id_ex_flush  = !reset || redir;
        b.ex_mem_flush = !reset || b.branch_taken_mem;
        {b.RegDst_id, b.ALUSrc_id, b.MemtoReg_id, b.RegWrite_id, b.MemRead_id,
         b.MemWrite_id, b.Branch_id, b.Jump_id, b.ALUOp_id, b.illegal_id} = bubble ? 11'd0 : dec;
    end

    // next state: a redirect (re)starts the wrong-path flush window; STALL blocks a second stall
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        if (redir) begin
            state_d = IMEM_LAT > 0 ? FLUSH : RUN;
            rd_d    = RW'(IMEM_LAT);
        end else if (state_q == FLUSH) begin
            state_d = rd_q > RW'(1) ? FLUSH : RUN;
            rd_d    = rd_q > RW'(0) ? rd_q - RW'(1) : RW'(0);
        end else begin
            state_d = stall ? STALL : RUN;
        end
    end

    // state and flush-window register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
        end
    end

    // saturating stall/redirect event counters, clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (redir && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: table-driven decode/stall vectors plus redirect, saturation and reset sequences
module tb_id_hazard_ctrl;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, ILL = 6'b111111;
    localparam logic [10:0] C_R    = 11'b1_0_0_1_0_0_0_0_10_0;
    localparam logic [10:0] C_LW   = 11'b0_1_1_1_1_0_0_0_00_0;
    localparam logic [10:0] C_SW   = 11'b0_1_0_0_0_1_0_0_00_0;
    localparam logic [10:0] C_BEQ  = 11'b0_0_0_0_0_0_1_0_01_0;
    localparam logic [10:0] C_ADDI = 11'b0_1_0_1_0_0_0_0_00_0;
    localparam logic [10:0] C_J    = 11'b0_0_0_0_0_0_0_1_00_0;
    localparam logic [10:0] C_ILL  = 11'b0_0_0_0_0_0_0_0_00_1;
    localparam logic [4:0]  HS_RUN = 5'b11000, HS_STL = 5'b00000, HS_RST = 5'b00111;

    typedef struct {
        logic [31:0] instr;
        logic        mr;
        logic [4:0]  rte;
        logic [10:0] ctl;
        logic [4:0]  hs;
        logic [15:0] sc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, cnt_clr, mr, jmp, btm;
    logic [31:0] instr;
    logic [4:0]  rte;
    logic [15:0] sc0, fc0;
    logic [1:0]  sc1, fc1;
    int          total = 0;
    int          bad = 0;
    vec_t        tbl[17];

    id_hazard_if if0();
    id_hazard_if if1();

    assign if0.instr_id = instr;
    assign if0.MemRead_ex = mr;
    assign if0.rt_ex = rte;
    assign if0.Jump_ex = jmp;
    assign if0.branch_taken_mem = btm;
    assign if1.instr_id = instr;
    assign if1.MemRead_ex = mr;
    assign if1.rt_ex = rte;
    assign if1.Jump_ex = jmp;
    assign if1.branch_taken_mem = btm;

    id_hazard_ctrl #(.IMEM_LAT(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .cnt_clr(cnt_clr), .b(if0), .stall_cnt(sc0), .flush_cnt(fc0)
    );
    id_hazard_ctrl #(.IMEM_LAT(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .cnt_clr(cnt_clr), .b(if1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt);
        return {op, rs, rt, 16'h0020};
    endfunction

    function automatic logic [10:0] ctl0();
        return {if0.RegDst_id, if0.ALUSrc_id, if0.MemtoReg_id, if0.RegWrite_id, if0.MemRead_id,
                if0.MemWrite_id, if0.Branch_id, if0.Jump_id, if0.ALUOp_id, if0.illegal_id};
    endfunction

    function automatic logic [4:0] hs0();
        return {if0.pc_write, if0.if_id_write, if0.if_id_flush, if0.id_ex_flush, if0.ex_mem_flush};
    endfunction

    function automatic logic [3:0] pf0();
        return {if0.pc_write, if0.if_id_flush, if0.id_ex_flush, if0.ex_mem_flush};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{mk(R, 8, 9),    1'b0, 5'd0, C_R,    HS_RUN, 16'd0};
        tbl[1]  = '{mk(LW, 1, 2),   1'b0, 5'd0, C_LW,   HS_RUN, 16'd0};
        tbl[2]  = '{mk(SW, 1, 2),   1'b0, 5'd0, C_SW,   HS_RUN, 16'd0};
        tbl[3]  = '{mk(BEQ, 1, 2),  1'b0, 5'd0, C_BEQ,  HS_RUN, 16'd0};
        tbl[4]  = '{mk(ADDI, 1, 2), 1'b0, 5'd0, C_ADDI, HS_RUN, 16'd0};
        tbl[5]  = '{mk(J, 0, 0),    1'b0, 5'd0, C_J,    HS_RUN, 16'd0};
        tbl[6]  = '{mk(ILL, 3, 4),  1'b0, 5'd0, C_ILL,  HS_RUN, 16'd0};
        tbl[7]  = '{mk(ADDI, 9, 8), 1'b1, 5'd8, C_ADDI, HS_RUN, 16'd0};
        tbl[8]  = '{mk(R, 0, 0),    1'b1, 5'd0, C_R,    HS_RUN, 16'd0};
        tbl[9]  = '{mk(SW, 3, 8),   1'b1, 5'd8, 11'd0,  HS_STL, 16'd0};
        tbl[10] = '{mk(SW, 3, 8),   1'b0, 5'd0, C_SW,   HS_RUN, 16'd1};
        tbl[11] = '{mk(R, 8, 9),    1'b1, 5'd8, 11'd0,  HS_STL, 16'd1};
        tbl[12] = '{mk(R, 8, 9),    1'b0, 5'd0, C_R,    HS_RUN, 16'd2};
        tbl[13] = '{mk(LW, 4, 8),   1'b1, 5'd8, C_LW,   HS_RUN, 16'd2};
        tbl[14] = '{mk(BEQ, 1, 8),  1'b1, 5'd8, 11'd0,  HS_STL, 16'd2};
        tbl[15] = '{mk(BEQ, 1, 8),  1'b0, 5'd0, C_BEQ,  HS_RUN, 16'd3};
        tbl[16] = '{mk(R, 1, 8),    1'b0, 5'd8, C_R,    HS_RUN, 16'd3};

        reset = 1'b0; cnt_clr = 1'b0; mr = 1'b0; jmp = 1'b0; btm = 1'b0;
        rte = 5'd0; instr = mk(R, 8, 9);
        @(negedge clk); #1;
        chk("rst_ctl", 32'(ctl0()), 32'(11'd0));
        chk("rst_hs", 32'(hs0()), 32'(HS_RST));
        chk("rst_sc", 32'(sc0), 0);
        chk("rst_fc", 32'(fc0), 0);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            instr = tbl[i].instr; mr = tbl[i].mr; rte = tbl[i].rte;
            #1;
            chk($sformatf("v%0d_ctl", i), 32'(ctl0()), 32'(tbl[i].ctl));
            chk($sformatf("v%0d_hs", i), 32'(hs0()), 32'(tbl[i].hs));
            chk($sformatf("v%0d_sc", i), 32'(sc0), 32'(tbl[i].sc));
        end

        // branch taken with a simultaneous load-use hazard
        @(negedge clk); instr = mk(R, 8, 9); mr = 1'b1; rte = 5'd8; btm = 1'b1; #1;
        chk("br_ctl", 32'(ctl0()), 0);
        chk("br_pf", 32'(pf0()), 32'(4'b1111));
        @(negedge clk); btm = 1'b0; mr = 1'b0; #1;
        chk("br_fl_ctl", 32'(ctl0()), 0);
        chk("br_fl_pf", 32'(pf0()), 32'(4'b1100));
        chk("br_fc", 32'(fc0), 1);
        chk("br_sc", 32'(sc0), 3);
        @(negedge clk); #1;
        chk("br_run_ctl", 32'(ctl0()), 32'(C_R));
        chk("br_run_hs", 32'(hs0()), 32'(HS_RUN));

        // jump re-issued during FLUSH extends the window
        @(negedge clk); jmp = 1'b1; #1;
        chk("j1_pf", 32'(pf0()), 32'(4'b1110));
        chk("j1_ctl", 32'(ctl0()), 0);
        @(negedge clk); #1;
        chk("j2_pw_iff", 32'({if0.pc_write, if0.if_id_flush}), 32'(2'b11));
        chk("j2_ctl", 32'(ctl0()), 0);
        @(negedge clk); jmp = 1'b0; #1;
        chk("j3_pf", 32'(pf0()), 32'(4'b1100));
        chk("j3_ctl", 32'(ctl0()), 0);
        @(negedge clk); #1;
        chk("j4_pf", 32'(pf0()), 32'(4'b1000));
        chk("j4_ctl", 32'(ctl0()), 32'(C_R));
        chk("j_fc", 32'(fc0), 3);

        // jump arriving in the cycle after a stall
        @(negedge clk); mr = 1'b1; rte = 5'd8; #1;
        chk("sj1_hs", 32'(hs0()), 32'(HS_STL));
        @(negedge clk); mr = 1'b0; jmp = 1'b1; #1;
        chk("sj2_pf", 32'(pf0()), 32'(4'b1110));
        chk("sj2_ctl", 32'(ctl0()), 0);
        @(negedge clk); jmp = 1'b0; #1;
        chk("sj3_pf", 32'(pf0()), 32'(4'b1100));
        @(negedge clk); #1;
        chk("sj4_hs", 32'(hs0()), 32'(HS_RUN));
        chk("sj_sc", 32'(sc0), 4);
        chk("sj_fc", 32'(fc0), 4);

        // counter saturation on the 2-bit instance
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; #1;
        chk("clr_sc0", 32'(sc0), 0);
        chk("clr_fc0", 32'(fc0), 0);
        chk("clr_sc1", 32'(sc1), 0);
        chk("clr_fc1", 32'(fc1), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); mr = 1'b1; rte = 5'd8;
        end
        @(negedge clk); mr = 1'b0; #1;
        chk("sat_sc1", 32'(sc1), 3);
        chk("sat_sc0", 32'(sc0), 5);
        chk("sat_fc1", 32'(fc1), 0);
        cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; #1;
        chk("sat_clr_sc1", 32'(sc1), 0);

        // reset pulsed in the middle of a flush
        @(negedge clk); btm = 1'b1;
        @(negedge clk); btm = 1'b0; #1;
        chk("rf_iff", 32'(if0.if_id_flush), 1);
        reset = 1'b0; #1;
        chk("rf_hs", 32'(hs0()), 32'(HS_RST));
        chk("rf_ctl", 32'(ctl0()), 0);
        chk("rf_fc", 32'(fc0), 0);
        chk("rf_sc", 32'(sc0), 0);
        @(negedge clk); reset = 1'b1; #1;
        chk("rel1_hs", 32'(hs0()), 32'(HS_RUN));
        chk("rel1_ctl", 32'(ctl0()), 32'(C_R));
        @(negedge clk); #1;
        chk("rel2_hs", 32'(hs0()), 32'(HS_RUN));
        chk("rel2_fc", 32'(fc0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
